ifetch: RTL and testbench
=========================

// Module: ifetch
// PURPOSE
//  Instruction fetch unit: owns the architectural PC, fetches words from instruction memory over a
//  req/ack interface and presents {pc, instr, offset, instr_index} to decode/branch logic via valid/ready.
//  Accepts the redirect target computed by the branch unit (new_pc) and restarts fetch there,
//  discarding any in-flight or buffered instruction. Sits between imem and the decode/br stage.
// PARAMETERS
//  RESET_PC   32'hBFC0_0000  PC loaded on reset
//  PC_STEP    4              sequential PC increment (bytes)
// PORTS
//  clk             in   1   clock; all state updates on posedge
//  resetn          in   1   synchronous reset, active-low
//  redir_valid     in   1   branch/jump taken; load redir_pc this cycle
//  redir_pc        in   32  redirect target (br new_pc); bits[1:0] ignored, forced 0
//  imem_req        out  1   fetch request, 1-cycle pulse per fetch
//  imem_addr       out  32  fetch address, valid when imem_req=1
//  imem_ack        in   1   read data valid (>=1 cycle after imem_req)
//  imem_rdata      in   32  instruction word, valid with imem_ack
//  if_valid        out  1   output instruction valid
//  if_ready        in   1   consumer accepts when if_valid&if_ready
//  if_pc           out  32  PC of presented instruction
//  if_instr        out  32  presented instruction word
//  if_offset       out  16  if_instr[15:0] (branch offset field)
//  if_instr_index  out  26  if_instr[25:0] (jump index field)
// BEHAVIOUR
//  Reset (resetn=0 at posedge): state=S_BOOT, fetch_pc=RESET_PC, if_valid=0, if_pc=RESET_PC,
//   if_instr=0, imem_req=0. Fields if_offset/if_instr_index are combinational slices of if_instr.
//  States: S_BOOT -> S_REQ unconditionally (one idle cycle after reset release).
//   S_REQ : imem_req=1, imem_addr=fetch_pc; -> S_WAIT next cycle.
//   S_WAIT: wait imem_ack. On ack: if_instr<=imem_rdata, if_pc<=fetch_pc, if_valid<=1,
//           fetch_pc<=fetch_pc+PC_STEP (mod 2^32, wraps 0xFFFF_FFFC->0), -> S_HOLD.
//   S_HOLD: hold outputs stable while if_valid&!if_ready. On if_valid&if_ready: if_valid<=0, -> S_REQ.
//   S_DRAIN: previous request abandoned; wait imem_ack, discard data, -> S_REQ.
//  imem_req is Moore (state==S_REQ); never two requests outstanding.
//  Redirect (redir_valid=1) has priority over every other event in every state except S_BOOT
//   (ignored there): fetch_pc<={redir_pc[31:2],2'b00}, if_valid<=0 (held instr discarded even if
//   if_ready=1 that cycle; the handshake still counts as consumed by the consumer, fetch does not care).
//   Next state: S_REQ from S_REQ (the issued request this cycle is outstanding -> S_DRAIN instead),
//   S_DRAIN from S_WAIT without ack, S_REQ from S_WAIT with same-cycle ack (data dropped),
//   S_REQ from S_HOLD, S_DRAIN stays S_DRAIN (ack that cycle -> S_REQ).
//  Latency: redirect at cycle N -> imem_req with new address at N+1 (or after drain ack +1).
//  imem_ack outside S_WAIT/S_DRAIN is a protocol error; ignored.
//  Reset mid-operation: outstanding request abandoned; imem must be reset concurrently.
//  Throughput: 1 instr per (3 + imem latency - 1) cycles at best; no prefetch.
// STRUCTURE
//  State encodings and RESET_PC default go in the shared marco.v include alongside the br_* codes.
//  One sub-module: ifetch_outreg (if_valid/if_pc/if_instr register with load/clear/hold).
//  FSM and fetch_pc register stay in ifetch.
// TESTING
//  1 Reset, imem ack latency 1, if_ready=1 -> imem_addr 0xBFC00000,0xBFC00004,0xBFC00008 in order;
//    if_pc matches, if_instr = returned words.
//  2 if_ready=0 for 5 cycles on instr 0x1000FFFF -> if_valid,if_pc,if_instr stable, no imem_req;
//    if_offset=16'hFFFF, if_instr_index=26'h000FFFF.
//  3 redir_valid, redir_pc=0x00400010 while S_WAIT (ack 3 cycles later) -> that ack dropped,
//    next imem_addr=0x00400010, if_valid stays 0 until new data.
//  4 redir_valid in same cycle as imem_ack -> data dropped, imem_req next cycle at redir target.
//  5 redir_pc=0xFFFFFFFD -> imem_addr 0xFFFFFFFC then 0x00000000 (low bits forced, wrap).
//  6 resetn=0 during S_HOLD -> next cycle if_valid=0, imem_req=0; after release one idle cycle
//    then imem_addr=RESET_PC.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// default reset PC / sequential step, and word-alignment helper.
package ifetch_pkg;

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;

  // Instruction addresses are always word aligned; low two bits are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ifetch_outreg.sv
// Output register presented to decode: valid/pc/instr with load, clear and hold.
module ifetch_outreg
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_instr,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] instr
);

  // Clear only drops valid; pc/instr keep their last value until the next load.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid <= 1'b0;
      pc    <= RESET_PC;
      instr <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      instr <= load_instr;
    end
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch unit: owns fetch_pc, issues one imem request at a time and
// presents each fetched word to decode; branch redirects restart fetch.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [15:0] if_offset,
  output logic [25:0] if_instr_index
);

  fetch_state_e state;
  logic [31:0]  fetch_pc;
  logic         redir_take;
  logic         out_load;
  logic         out_clear;

  always_comb begin
    redir_take = redir_valid && (state != S_BOOT);
    out_load   = (state == S_WAIT) && imem_ack && !redir_valid;
    out_clear  = redir_take || ((state == S_HOLD) && if_valid && if_ready);
  end

  // Redirect wins over everything once out of boot. A request still in flight
  // (just issued, or unanswered) must be drained before fetching the new target.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= S_BOOT;
      fetch_pc <= RESET_PC;
      imem_req <= 1'b0;
    end else if (redir_take) begin
      fetch_pc <= align_word(redir_pc);
      if ((state == S_REQ) ||
          (((state == S_WAIT) || (state == S_DRAIN)) && !imem_ack)) begin
        state    <= S_DRAIN;
        imem_req <= 1'b0;
      end else begin
        state    <= S_REQ;
        imem_req <= 1'b1;
      end
    end else begin
      case (state)
        S_BOOT: begin
          state    <= S_REQ;
          imem_req <= 1'b1;
        end
        S_REQ: begin
          state    <= S_WAIT;
          imem_req <= 1'b0;
        end
        S_WAIT: begin
          if (imem_ack) begin
            state    <= S_HOLD;
            fetch_pc <= fetch_pc + PC_STEP;
          end
        end
        S_HOLD: begin
          if (if_valid && if_ready) begin
            state    <= S_REQ;
            imem_req <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (imem_ack) begin
            state    <= S_REQ;
            imem_req <= 1'b1;
          end
        end
        default: begin
          state    <= S_BOOT;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr = fetch_pc;

  ifetch_outreg #(
    .RESET_PC(RESET_PC)
  ) u_outreg (
    .clk       (clk),
    .resetn    (resetn),
    .load      (out_load),
    .clear     (out_clear),
    .load_pc   (fetch_pc),
    .load_instr(imem_rdata),
    .valid     (if_valid),
    .pc        (if_pc),
    .instr     (if_instr)
  );

  assign if_offset      = if_instr[15:0];
  assign if_instr_index = if_instr[25:0];

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed scenarios plus randomized traffic,
// checked against a transaction-level model of fetch order and handshakes.
module tb_ifetch;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        redir_valid = 1'b0;
  logic [31:0] redir_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [15:0] if_offset;
  logic [25:0] if_instr_index;

  ifetch dut (
    .clk           (clk),
    .resetn        (resetn),
    .redir_valid   (redir_valid),
    .redir_pc      (redir_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_pc         (if_pc),
    .if_instr      (if_instr),
    .if_offset     (if_offset),
    .if_instr_index(if_instr_index)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: where the next fetch must go and what the consumer should see.
  logic [31:0] exp_next, last_req, last_data, override_word, redir_target;
  logic        outstanding, stale, started, override_en;
  logic        exp_req, exp_valid;
  logic        obs_req, obs_valid;
  logic [31:0] obs_addr;
  int          cnt, idle, seen_valid;
  int          lat_cfg, ready_cfg;
  logic        random_redir, redir_req, redir_on_ack, redir_fired;
  logic [31:0] req_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] imem_word(input logic [31:0] addr);
    return {addr[15:0], ~addr[31:16]} ^ 32'h3C5A_0F96;
  endfunction

  task automatic model_init();
    exp_next    = RST_PC;
    outstanding = 1'b0;
    stale       = 1'b0;
    started     = 1'b0;
    exp_req     = 1'b1;
    exp_valid   = 1'b0;
    idle        = 0;
  endtask

  task automatic do_reset(input int cycles);
    resetn      = 1'b0;
    redir_valid = 1'b0;
    imem_ack    = 1'b0;
    if_ready    = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_req",   32'(imem_req), 32'd0);
    chk("rst_pc",    if_pc, RST_PC);
    chk("rst_instr", if_instr, 32'd0);
    resetn = 1'b1;
    model_init();
  endtask

  // One clock: observe and check outputs, then choose inputs for the next edge.
  task automatic step();
    logic        ack, redir, rdy;
    logic [31:0] tgt, data;
    @(posedge clk);
    @(negedge clk);
    obs_req   = imem_req;
    obs_valid = if_valid;
    obs_addr  = imem_addr;
    chk("req_timing",   32'(obs_req),   32'(exp_req));
    chk("valid_timing", 32'(obs_valid), 32'(exp_valid));
    if (obs_valid) begin
      seen_valid++;
      chk("if_pc",    if_pc, last_req);
      chk("if_instr", if_instr, last_data);
      chk("if_offset", 32'(if_offset), 32'(last_data[15:0]));
      chk("if_index",  32'(if_instr_index), 32'(last_data[25:0]));
    end
    if (obs_req) begin
      chk("req_addr", obs_addr, exp_next);
      req_log.push_back(obs_addr);
      last_req    = obs_addr;
      exp_next    = obs_addr + 32'd4;
      outstanding = 1'b1;
      stale       = 1'b0;
      started     = 1'b1;
      cnt         = (lat_cfg == 0) ? int'($urandom_range(4, 1)) : lat_cfg;
      idle        = 0;
    end else begin
      idle++;
      if (idle > 60) begin
        chk("liveness", 32'(idle), 32'd0);
        idle = 0;
      end
    end

    ack = 1'b0;
    if (outstanding && !obs_req) begin
      cnt--;
      if (cnt == 0) begin
        ack         = 1'b1;
        outstanding = 1'b0;
      end
    end
    redir = 1'b0;
    tgt   = $urandom;
    if (redir_req) begin
      redir     = 1'b1;
      tgt       = redir_target;
      redir_req = 1'b0;
    end else if (redir_on_ack && ack) begin
      redir        = 1'b1;
      tgt          = redir_target;
      redir_on_ack = 1'b0;
      redir_fired  = 1'b1;
    end else if (random_redir && started && ($urandom_range(11, 0) == 0)) begin
      redir = 1'b1;
    end
    case (ready_cfg)
      0:       rdy = 1'b0;
      1:       rdy = 1'b1;
      default: rdy = 1'($urandom_range(1, 0));
    endcase
    data = ack ? (override_en ? override_word : imem_word(last_req)) : $urandom;

    exp_req   = (ack && (stale || redir)) || (obs_valid && (rdy || redir));
    exp_valid = (ack && !stale && !redir) || (obs_valid && !rdy && !redir);
    if (ack && !stale && !redir) last_data = data;
    if (redir) begin
      stale    = 1'b1;
      exp_next = tgt & 32'hFFFF_FFFC;
    end

    imem_ack    = ack;
    imem_rdata  = data;
    if_ready    = rdy;
    redir_valid = redir;
    redir_pc    = tgt;
  endtask

  task automatic wait_req(input string tag);
    seen_valid = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (obs_req) break;
    end
    chk(tag, 32'(obs_req), 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 60; i++) begin
      step();
      if (obs_valid) break;
    end
    chk(tag, 32'(obs_valid), 32'd1);
  endtask

  initial begin
    logic [31:0] held_pc;
    lat_cfg      = 1;
    ready_cfg    = 1;
    random_redir = 1'b0;
    redir_req    = 1'b0;
    redir_on_ack = 1'b0;
    redir_fired  = 1'b0;
    override_en  = 1'b0;
    override_word = 32'h1000_FFFF;
    redir_target = '0;
    last_req     = '0;
    last_data    = '0;
    cnt          = 0;
    seen_valid   = 0;

    // Sequential fetch from the reset vector.
    do_reset(2);
    req_log.delete();
    wait_req("t1_req0");
    wait_req("t1_req1");
    wait_req("t1_req2");
    chk("t1_addr0", req_log[0], 32'hBFC0_0000);
    chk("t1_addr1", req_log[1], 32'hBFC0_0004);
    chk("t1_addr2", req_log[2], 32'hBFC0_0008);

    // Consumer stall holds the instruction stable with no new fetch.
    ready_cfg   = 0;
    override_en = 1'b1;
    wait_valid("t2_valid_seen");
    held_pc = if_pc;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_valid",  32'(if_valid), 32'd1);
      chk("t2_noreq",  32'(imem_req), 32'd0);
      chk("t2_pc",     if_pc, held_pc);
      chk("t2_instr",  if_instr, 32'h1000_FFFF);
      chk("t2_offset", 32'(if_offset), 32'h0000_FFFF);
      chk("t2_index",  32'(if_instr_index), 32'h000_FFFF);
    end
    override_en = 1'b0;
    ready_cfg   = 1;

    // Redirect while waiting on a slow ack: ack is drained and dropped.
    lat_cfg = 3;
    wait_req("t3_req");
    redir_req    = 1'b1;
    redir_target = 32'h0040_0010;
    step();
    wait_req("t3_newreq");
    chk("t3_addr", obs_addr, 32'h0040_0010);
    chk("t3_novalid", 32'(seen_valid), 32'd0);
    wait_valid("t3_valid_seen");
    chk("t3_pc", if_pc, 32'h0040_0010);

    // Redirect coinciding with the ack: data dropped, refetch next cycle.
    lat_cfg      = 2;
    redir_target = 32'h0000_1230;
    redir_fired  = 1'b0;
    redir_on_ack = 1'b1;
    for (int i = 0; i < 40 && !redir_fired; i++) step();
    chk("t4_fired", 32'(redir_fired), 32'd1);
    step();
    chk("t4_req",   32'(obs_req), 32'd1);
    chk("t4_addr",  obs_addr, 32'h0000_1230);
    chk("t4_valid", 32'(obs_valid), 32'd0);

    // Misaligned target near the top of memory: low bits forced, pc wraps.
    lat_cfg      = 1;
    redir_req    = 1'b1;
    redir_target = 32'hFFFF_FFFD;
    step();
    wait_req("t5_req_a");
    chk("t5_addr_a", obs_addr, 32'hFFFF_FFFC);
    wait_req("t5_req_b");
    chk("t5_addr_b", obs_addr, 32'h0000_0000);

    // Reset while holding an instruction.
    ready_cfg = 0;
    wait_valid("t6_valid_seen");
    do_reset(1);
    step();
    chk("t6_req",  32'(obs_req), 32'd1);
    chk("t6_addr", obs_addr, RST_PC);

    // Randomized traffic: latency, back-pressure and redirects.
    lat_cfg      = 0;
    ready_cfg    = 2;
    random_redir = 1'b1;
    repeat (1500) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
